// File: rtl/pixel_writer_pkg.sv
// rtl/pixel_writer_pkg.sv - shared pixel/framebuffer types for the raymarcher, pixel writer and display reader
//
// Purpose: one place for the RGB565 pixel type, the framebuffer entry
// {addr, data} and the default image dimensions.
// Ports: none (package).
package pixel_writer_pkg;

   localparam int DEF_WIDTH  = 300;
   localparam int DEF_HEIGHT = 300;

   // Address field is wide enough for any image this family supports;
   // each user truncates it to its own $clog2(WIDTH*HEIGHT).
   localparam int FB_ADDR_MAX_W = 32;

   typedef logic [15:0] rgb565_t;

   typedef struct packed {
      logic [FB_ADDR_MAX_W-1:0] addr;
      rgb565_t                  data;
   } fb_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - small synchronous FIFO for framebuffer entries
//
// Purpose: buffers accepted pixels until the framebuffer grants a write.
// Ports:
//   clk_in, rst_in     clock, asynchronous active-low reset (empties FIFO)
//   push_in, push_data_in   write request/data (ignored when full)
//   pop_in             remove head entry (ignored when empty)
//   head_out           current head entry (undefined when empty)
//   full_out, empty_out occupancy flags, from registered state only
module pixel_fifo #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = logic [47:0]
) (
   input  logic   clk_in,
   input  logic   rst_in,
   input  logic   push_in,
   input  entry_t push_data_in,
   input  logic   pop_in,
   output entry_t head_out,
   output logic   full_out,
   output logic   empty_out
);

   localparam int PTR_W = $clog2(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full_out  = (count == (PTR_W+1)'(DEPTH));
   assign empty_out = (count == '0);

   // A pop in the same cycle never frees room for a push when full.
   assign do_push = push_in & ~full_out;
   assign do_pop  = pop_in & ~empty_out;

   assign head_out = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: empty_out masks stale contents.
   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr] <= push_data_in;
   end

endmodule

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - range-checks finished pixels and writes them to the framebuffer in RGB565
//
// Purpose: accepts pixels from the raymarcher, drops out-of-range ones,
// buffers the rest and writes them whenever the framebuffer grants access.
// Ports:
//   clk_in, rst_in        clock, asynchronous active-low reset
//   pixel_valid_in/pixel_ready_out   pixel handshake
//   pixel_x_in, pixel_y_in           33-bit unsigned coordinates
//   red_in, green_in, blue_in        8-bit colour
//   fb_grant_in           framebuffer port available this cycle
//   fb_we_out, fb_addr_out, fb_data_out   framebuffer write
//   frame_done_out        one-cycle pulse after the last pixel of a frame
//   drop_count_out        saturating count of rejected pixels
module pixel_writer
   import pixel_writer_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int HEIGHT     = DEF_HEIGHT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                 clk_in,
   input  logic                                 rst_in,
   input  logic                                 pixel_valid_in,
   output logic                                 pixel_ready_out,
   input  logic [32:0]                          pixel_x_in,
   input  logic [32:0]                          pixel_y_in,
   input  logic [7:0]                           red_in,
   input  logic [7:0]                           green_in,
   input  logic [7:0]                           blue_in,
   input  logic                                 fb_grant_in,
   output logic                                 fb_we_out,
   output logic [$clog2(WIDTH*HEIGHT)-1:0]      fb_addr_out,
   output logic [15:0]                          fb_data_out,
   output logic                                 frame_done_out,
   output logic [15:0]                          drop_count_out
);

   localparam int TOTAL  = WIDTH * HEIGHT;
   localparam int ADDR_W = $clog2(TOTAL);
   localparam int CNT_W  = $clog2(TOTAL + 1);

   logic              ready_q;
   logic              fifo_full;
   logic              fifo_empty;
   logic              accept;
   logic              in_range;
   logic [ADDR_W-1:0] addr;
   fb_entry_t         push_entry;
   fb_entry_t         head;
   logic [CNT_W-1:0]  pix_count;
   logic              unused_colour_lsbs;

   initial begin
      assert (FIFO_DEPTH >= 2 && (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);
   end

   // ready_q keeps ready low through reset and raises it on the first edge after.
   assign pixel_ready_out = ready_q & ~fifo_full;
   assign accept          = pixel_valid_in & pixel_ready_out;
   assign in_range        = (pixel_x_in < 33'(WIDTH)) && (pixel_y_in < 33'(HEIGHT));

   // Only the low ADDR_W bits survive truncation, so the product is formed at that width.
   assign addr = pixel_y_in[ADDR_W-1:0] * ADDR_W'(WIDTH) + pixel_x_in[ADDR_W-1:0];

   assign push_entry.addr = FB_ADDR_MAX_W'(addr);
   assign push_entry.data = {red_in[7:3], green_in[7:2], blue_in[7:3]};
   assign unused_colour_lsbs = ^{red_in[2:0], green_in[1:0], blue_in[2:0]};

   pixel_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (fb_entry_t)
   ) u_fifo (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .push_in      (accept & in_range),
      .push_data_in (push_entry),
      .pop_in       (fb_we_out),
      .head_out     (head),
      .full_out     (fifo_full),
      .empty_out    (fifo_empty)
   );

   assign fb_we_out   = ~fifo_empty & fb_grant_in;
   assign fb_addr_out = fifo_empty ? '0 : ADDR_W'(head.addr);
   assign fb_data_out = fifo_empty ? '0 : head.data;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ready_q        <= 1'b0;
         drop_count_out <= '0;
         pix_count      <= '0;
         frame_done_out <= 1'b0;
      end else begin
         ready_q <= 1'b1;

         if (accept && !in_range && drop_count_out != 16'hFFFF)
            drop_count_out <= drop_count_out + 16'd1;

         frame_done_out <= 1'b0;
         if (fb_we_out) begin
            if (pix_count == CNT_W'(TOTAL - 1)) begin
               pix_count      <= '0;
               frame_done_out <= 1'b1;
            end else begin
               pix_count <= pix_count + 1'b1;
            end
         end
      end
   end

endmodule
